// File: rtl/spi_slave_rx_shifter.sv
// Purpose : SPI slave receive deserialiser. Shifts SDI pad data (1 bit std or 4 bit quad)
//           into a 32-bit word and pulses rx_data_valid when the programmed field is complete.
// Latency : rx_data_valid is high in the cycle after the edge that samples the field's last bit.
//           There is no backpressure. The controller must consume rx_data in the valid cycle.
//
// Ports:
//   sclk, sys_rstn      SPI clock (posedge); synchronous active-low reset
//   cs                  chip select, 1 = deselected (clears the frame)
//   en_quad, sdi[3:0]   width select and pad data (sdi[0] only in std mode)
//   rx_counter[7:0]     new field target (last index, 0-based), loaded when rx_counter_upd=1
//   rx_data[31:0]       shift register, newest bit/nibble at LSB
//   rx_data_valid       one-cycle field-complete pulse
//   rx_abort            one-cycle pulse when cs rises during a partial field
//   rx_word_cnt[15:0]   fields completed since last deselect, saturating
module spi_slave_rx_shifter #(
  parameter int unsigned CMD_BITS_STD  = 8,
  parameter int unsigned CMD_BITS_QUAD = 2
) (
  input  logic        sclk,
  input  logic        sys_rstn,
  input  logic        cs,
  input  logic        en_quad,
  input  logic [3:0]  sdi,
  input  logic [7:0]  rx_counter,
  input  logic        rx_counter_upd,
  output logic [31:0] rx_data,
  output logic        rx_data_valid,
  output logic        rx_abort,
  output logic [15:0] rx_word_cnt
);

  localparam logic [7:0] TGT_STD  = 8'(CMD_BITS_STD - 1);
  localparam logic [7:0] TGT_QUAD = 8'(CMD_BITS_QUAD - 1);

  logic [7:0]  cnt_q;
  logic [7:0]  tgt_q;
  logic [31:0] data_q;
  logic        valid_q;
  logic        abort_q;
  logic [15:0] words_q;

  logic [7:0]  tgt_eff;
  logic [31:0] data_next;
  logic [15:0] words_inc;
  logic        field_done;

  // A retarget issued in the valid cycle applies to the edge that samples the
  // next field's first bit. This keeps fields back-to-back with no lost edges.
  assign tgt_eff    = rx_counter_upd ? rx_counter : tgt_q;
  assign field_done = (cnt_q == tgt_eff);
  assign data_next  = en_quad ? {data_q[27:0], sdi} : {data_q[30:0], sdi[0]};
  assign words_inc  = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;

  always_ff @(posedge sclk) begin
    if (!sys_rstn) begin
      cnt_q   <= 8'd0;
      tgt_q   <= TGT_STD;
      data_q  <= 32'd0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      words_q <= 16'd0;
    end else if (cs) begin
      // Deselect re-arms for a command of the current width. Only a partial
      // field in flight is reported as an abort.
      cnt_q   <= 8'd0;
      tgt_q   <= en_quad ? TGT_QUAD : TGT_STD;
      data_q  <= 32'd0;
      valid_q <= 1'b0;
      abort_q <= (cnt_q != 8'd0);
      words_q <= 16'd0;
    end else begin
      tgt_q   <= tgt_eff;
      data_q  <= data_next;
      abort_q <= 1'b0;
      if (field_done) begin
        valid_q <= 1'b1;
        cnt_q   <= 8'd0;
        words_q <= words_inc;
      end else begin
        // If the target was lowered below cnt, this wraps through 8'hFF.
        valid_q <= 1'b0;
        cnt_q   <= cnt_q + 8'd1;
      end
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_abort      = abort_q;
  assign rx_word_cnt   = words_q;

endmodule

// File: tb/tb_spi_slave_rx_shifter.sv
module tb_spi_slave_rx_shifter;

  logic        sclk;
  logic        sys_rstn;
  logic        cs;
  logic        en_quad;
  logic [3:0]  sdi;
  logic [7:0]  rx_counter;
  logic        rx_counter_upd;
  logic [31:0] rx_data;
  logic        rx_data_valid;
  logic        rx_abort;
  logic [15:0] rx_word_cnt;

  spi_slave_rx_shifter #(.CMD_BITS_STD(8), .CMD_BITS_QUAD(2)) dut (
    .sclk(sclk), .sys_rstn(sys_rstn), .cs(cs), .en_quad(en_quad), .sdi(sdi),
    .rx_counter(rx_counter), .rx_counter_upd(rx_counter_upd),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_abort(rx_abort),
    .rx_word_cnt(rx_word_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_err = 0;
  int misuse = 0;

  // Reference model: field progress as a bit count, data as a number built by
  // base-2 / base-16 accumulation modulo 2^32.
  int     m_cnt;
  int     m_tgt;
  longint m_data;
  bit     m_valid;
  bit     m_abort;
  int     m_words;

  task automatic model_edge(input logic rstn_i, input logic cs_i, input logic quad_i,
                            input logic [3:0] sdi_i, input logic [7:0] rc_i, input logic upd_i);
    int t;
    if (!rstn_i) begin
      m_cnt = 0; m_tgt = 7; m_data = 0; m_valid = 0; m_abort = 0; m_words = 0;
    end else if (cs_i) begin
      m_abort = (m_cnt != 0);
      m_cnt = 0; m_tgt = quad_i ? 1 : 7; m_data = 0; m_valid = 0; m_words = 0;
    end else begin
      t = upd_i ? int'(rc_i) : m_tgt;
      if (t < m_cnt) misuse++;
      m_tgt = t;
      if (quad_i) m_data = (m_data * 16 + longint'(sdi_i)) % 64'h1_0000_0000;
      else        m_data = (m_data * 2 + longint'(sdi_i[0])) % 64'h1_0000_0000;
      m_abort = 0;
      if (m_cnt == t) begin
        m_valid = 1; m_cnt = 0;
        if (m_words < 65535) m_words++;
      end else begin
        m_valid = 0; m_cnt = (m_cnt + 1) % 256;
      end
    end
  endtask

  // Apply inputs for one edge, advance the model, then settle before sampling.
  task automatic drive(input logic rstn_i, input logic cs_i, input logic quad_i,
                       input logic [3:0] sdi_i, input logic [7:0] rc_i, input logic upd_i);
    sys_rstn = rstn_i; cs = cs_i; en_quad = quad_i; sdi = sdi_i;
    rx_counter = rc_i; rx_counter_upd = upd_i;
    @(posedge sclk);
    model_edge(rstn_i, cs_i, quad_i, sdi_i, rc_i, upd_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, 32'(rx_data_valid), 32'(m_valid));
    check({tag, ".abort"}, 32'(rx_abort), 32'(m_abort));
    check({tag, ".data"}, rx_data, m_data[31:0]);
    check({tag, ".words"}, 32'(rx_word_cnt), 32'(m_words));
    check({tag, ".excl"}, 32'(rx_data_valid & rx_abort), 32'd0);
  endtask

  typedef struct {
    logic        rstn;
    logic        cs;
    logic        quad;
    logic [3:0]  sdi;
    logic [7:0]  rc;
    logic        upd;
    logic        e_valid;
    logic        e_abort;
    logic [31:0] e_data;
    logic [15:0] e_words;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rstn, logic cs_i, logic quad, logic [3:0] s, logic [7:0] rc,
                              logic upd, logic ev, logic ea, logic [31:0] ed, logic [15:0] ew);
    vec_t v;
    v.rstn = rstn; v.cs = cs_i; v.quad = quad; v.sdi = s; v.rc = rc; v.upd = upd;
    v.e_valid = ev; v.e_abort = ea; v.e_data = ed; v.e_words = ew;
    return v;
  endfunction

  initial begin
    logic [31:0] word;
    logic [3:0]  s;
    int          hit;
    logic        q;
    logic        r_rstn, r_cs, r_upd;
    logic [7:0]  r_rc;

    sys_rstn = 1'b0; cs = 1'b0; en_quad = 1'b0; sdi = 4'h0;
    rx_counter = 8'h0; rx_counter_upd = 1'b0;

    // Reset with cs low and sdi toggling, then 0xEB MSB-first in std mode,
    // one edge into the next field, then a deselect (abort) and a second deselect.
    vecs.push_back(mk(0, 0, 0, 4'hF, 8'h00, 0, 0, 0, 32'h0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 8'h00, 0, 0, 0, 32'h0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 4'hF, 8'h00, 0, 0, 0, 32'h01, 16'd0));
    vecs.push_back(mk(1, 0, 0, 4'h1, 8'h00, 0, 0, 0, 32'h03, 16'd0));
    vecs.push_back(mk(1, 0, 0, 4'hB, 8'h00, 0, 0, 0, 32'h07, 16'd0));
    vecs.push_back(mk(1, 0, 0, 4'hE, 8'h00, 0, 0, 0, 32'h0E, 16'd0));
    vecs.push_back(mk(1, 0, 0, 4'h1, 8'h00, 0, 0, 0, 32'h1D, 16'd0));
    vecs.push_back(mk(1, 0, 0, 4'h8, 8'h00, 0, 0, 0, 32'h3A, 16'd0));
    vecs.push_back(mk(1, 0, 0, 4'h1, 8'h00, 0, 0, 0, 32'h75, 16'd0));
    vecs.push_back(mk(1, 0, 0, 4'h3, 8'h00, 0, 1, 0, 32'hEB, 16'd1));
    vecs.push_back(mk(1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 32'h1D6, 16'd1));
    vecs.push_back(mk(1, 1, 0, 4'h0, 8'h00, 0, 0, 1, 32'h0, 16'd0));
    vecs.push_back(mk(1, 1, 0, 4'h0, 8'h00, 0, 0, 0, 32'h0, 16'd0));

    foreach (vecs[i]) begin
      drive(vecs[i].rstn, vecs[i].cs, vecs[i].quad, vecs[i].sdi, vecs[i].rc, vecs[i].upd);
      check($sformatf("vec%0d.valid", i), 32'(rx_data_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.abort", i), 32'(rx_abort), 32'(vecs[i].e_abort));
      check($sformatf("vec%0d.data", i), rx_data, vecs[i].e_data);
      check($sformatf("vec%0d.words", i), 32'(rx_word_cnt), 32'(vecs[i].e_words));
    end

    // Quad command A,5, then retarget to 8 nibbles in the valid cycle.
    drive(1, 1, 1, 4'h0, 8'h00, 0);
    drive(1, 0, 1, 4'hA, 8'h00, 0);
    check_model("quad_cmd1");
    drive(1, 0, 1, 4'h5, 8'h00, 0);
    check("quad_cmd.valid", 32'(rx_data_valid), 32'd1);
    check("quad_cmd.data", 32'(rx_data[7:0]), 32'hA5);
    word = 32'h12345678;
    hit = -1;
    for (int i = 0; i < 8; i++) begin
      s = word[31 - 4*i -: 4];
      drive(1, 0, 1, s, 8'd7, (i == 0));
      check_model($sformatf("quad_w%0d", i));
      if (rx_data_valid && hit < 0) hit = i;
    end
    check("quad_word.edge", 32'(hit), 32'd7);
    check("quad_word.data", rx_data, 32'h12345678);

    // Back-to-back std fields: 8-bit command, then 32 bits retargeted in the valid cycle.
    drive(1, 1, 0, 4'h0, 8'h00, 0);
    word = 32'h0000003C;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, {3'($urandom_range(0, 7)), word[7 - i]}, 8'h00, 0);
    end
    check("b2b_cmd.valid", 32'(rx_data_valid), 32'd1);
    word = 32'hDEADBEEF;
    hit = -1;
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, {3'($urandom_range(0, 7)), word[31 - i]}, 8'd31, (i == 0));
      check_model($sformatf("b2b_b%0d", i));
      if (rx_data_valid && hit < 0) hit = i;
    end
    check("b2b.edge", 32'(hit), 32'd31);
    check("b2b.data", rx_data, 32'hDEADBEEF);
    check("b2b.words", 32'(rx_word_cnt), 32'd2);

    // Abort after 5 bits of a field. A second deselect at cnt==0 must stay quiet.
    drive(1, 1, 0, 4'h0, 8'h00, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 4'h1, 8'h00, 0);
    drive(1, 1, 0, 4'h0, 8'h00, 0);
    check("abort.pulse", 32'(rx_abort), 32'd1);
    check("abort.valid", 32'(rx_data_valid), 32'd0);
    check("abort.data", rx_data, 32'd0);
    check("abort.words", 32'(rx_word_cnt), 32'd0);
    drive(1, 1, 0, 4'h0, 8'h00, 0);
    check("abort.idle", 32'(rx_abort), 32'd0);

    // rx_counter_upd is ignored while deselected, so the default 8-bit command still applies.
    drive(1, 1, 0, 4'hF, 8'd3, 1);
    hit = -1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 4'h1, 8'd3, 0);
      if (rx_data_valid && hit < 0) hit = i;
    end
    check("prio.upd_ignored", 32'(hit), 32'd7);
    // Reset wins over cs and a pending retarget.
    drive(1, 0, 0, 4'h1, 8'd0, 0);
    drive(1, 0, 0, 4'h1, 8'd0, 0);
    drive(0, 1, 1, 4'hF, 8'd3, 1);
    check("prio.rst_abort", 32'(rx_abort), 32'd0);
    check("prio.rst_data", rx_data, 32'd0);
    check("prio.rst_words", 32'(rx_word_cnt), 32'd0);
    check_model("prio.rst");

    // Randomised traffic against the reference model.
    q = 1'b0;
    drive(1, 1, 0, 4'h0, 8'h00, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) q = ~q;
      r_rstn = ($urandom_range(0, 199) != 0);
      r_cs   = ($urandom_range(0, 29) == 0);
      // Retarget mostly in the valid cycle, like the controller, and rarely mid-field.
      r_upd  = rx_data_valid ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
      r_rc   = 8'($urandom_range(0, 40));
      drive(r_rstn, r_cs, q, 4'($urandom_range(0, 15)), r_rc, r_upd);
      check_model($sformatf("rand%0d", i));
    end
    $display("note: %0d mid-field retargets below current count (controller misuse)", misuse);

    // Word counter saturation: single-edge fields held for more than 65535 edges.
    drive(1, 1, 0, 4'h0, 8'h00, 0);
    for (int i = 0; i < 65540; i++) begin
      drive(1, 0, 0, 4'($urandom_range(0, 15)), 8'd0, 1);
      if (i == 2) check("sat.early_words", 32'(rx_word_cnt), 32'd3);
    end
    check("sat.words", 32'(rx_word_cnt), 32'hFFFF);
    check("sat.valid", 32'(rx_data_valid), 32'd1);
    check_model("sat");
    drive(1, 1, 0, 4'h0, 8'h00, 0);
    check("sat.clear_words", 32'(rx_word_cnt), 32'd0);
    check("sat.no_abort", 32'(rx_abort), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
